// File: rtl/gl_raster_scan_if.sv
// rtl/gl_raster_scan_if.sv - triangle-in / pixel-out stream bundle for gl_raster_scan
interface gl_raster_scan_if #(
  parameter int COORD_W = 12,
  parameter int NUM_CH  = 3,
  parameter int CH_W    = 8
);
  logic                   tri_valid;
  logic                   tri_ready;
  logic [2*COORD_W-1:0]   tri_v0;
  logic [2*COORD_W-1:0]   tri_v1;
  logic [2*COORD_W-1:0]   tri_v2;
  logic [NUM_CH*CH_W-1:0] tri_color;
  logic                   pix_valid;
  logic                   pix_ready;
  logic [COORD_W-1:0]     pix_x;
  logic [COORD_W-1:0]     pix_y;
  logic [NUM_CH*CH_W-1:0] pix_color;
  logic                   tri_done;

  modport master (
    output tri_valid, tri_v0, tri_v1, tri_v2, tri_color, pix_ready,
    input  tri_ready, pix_valid, pix_x, pix_y, pix_color, tri_done
  );

  modport slave (
    input  tri_valid, tri_v0, tri_v1, tri_v2, tri_color, pix_ready,
    output tri_ready, pix_valid, pix_x, pix_y, pix_color, tri_done
  );
endinterface

// File: rtl/gl_raster_scan.sv
// rtl/gl_raster_scan.sv - bbox-walking triangle scan converter with incremental edge functions
// Define GL_RAST_BACKFACE_CULL_EN to drop negative-area (clockwise) triangles.
module gl_raster_scan #(
  parameter int COORD_W  = 12,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int NUM_CH   = 3,
  parameter int CH_W     = 8
) (
  input logic             clk,
  input logic             rst_n,
  gl_raster_scan_if.slave bus
);
  localparam int EW = 2*COORD_W + 2;
  localparam int MW = EW + 1;
  localparam int CW = NUM_CH*CH_W;
`ifdef GL_RAST_BACKFACE_CULL_EN
  localparam bit CULL_BACKFACE = 1'b1;
`else
  localparam bit CULL_BACKFACE = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, SETUP1, SETUP2, SCAN, DRAIN} state_t;
  typedef logic signed [COORD_W-1:0] crd_t;
  typedef logic signed [COORD_W:0]   dlt_t;
  typedef logic signed [EW-1:0]      edg_t;
  typedef logic signed [MW-1:0]      wide_t;

  state_t             state_q;
  crd_t               vx_q [3];
  crd_t               vy_q [3];
  logic [CW-1:0]      color_q;
  dlt_t               dx_q [3];
  dlt_t               dy_q [3];
  logic [COORD_W-1:0] minx_q, maxx_q, miny_q, maxy_q;
  logic [COORD_W-1:0] x_q, y_q;
  edg_t               e_q [3];
  edg_t               row_q [3];
  edg_t               stepx_q [3];
  edg_t               stepy_q [3];
  logic               tri_ready_q, pix_valid_q, tri_done_q;
  logic [COORD_W-1:0] pix_x_q, pix_y_q;
  logic [CW-1:0]      pix_color_q;

  function automatic crd_t min3(input crd_t a, input crd_t b, input crd_t c);
    crd_t m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic crd_t max3(input crd_t a, input crd_t b, input crd_t c);
    crd_t m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Evaluated one bit wider than the edge registers; the true value always fits EW.
  function automatic edg_t edge_at(input dlt_t dx, input dlt_t dy, input crd_t ax,
                                   input crd_t ay, input logic [COORD_W-1:0] px,
                                   input logic [COORD_W-1:0] py);
    wide_t w;
    w = wide_t'(dx) * (wide_t'({1'b0, py}) - wide_t'(ay))
      - wide_t'(dy) * (wide_t'({1'b0, px}) - wide_t'(ax));
    return edg_t'(w);
  endfunction

  crd_t  lox, hix, loy, hiy;
  int    clx, chx, cly, chy;
  logic  bbox_empty;
  wide_t area_w;
  logic  area_neg;
  edg_t  e_init [3];

  always_comb begin
    lox = min3(vx_q[0], vx_q[1], vx_q[2]);
    hix = max3(vx_q[0], vx_q[1], vx_q[2]);
    loy = min3(vy_q[0], vy_q[1], vy_q[2]);
    hiy = max3(vy_q[0], vy_q[1], vy_q[2]);
    clx = (int'(lox) < 0) ? 0 : int'(lox);
    cly = (int'(loy) < 0) ? 0 : int'(loy);
    chx = (int'(hix) > SCREEN_W-1) ? SCREEN_W-1 : int'(hix);
    chy = (int'(hiy) > SCREEN_H-1) ? SCREEN_H-1 : int'(hiy);
    bbox_empty = (clx > chx) || (cly > chy);
  end

  always_comb begin
    area_w = wide_t'(dx_q[0]) * (wide_t'(vy_q[2]) - wide_t'(vy_q[0]))
           - wide_t'(dy_q[0]) * (wide_t'(vx_q[2]) - wide_t'(vx_q[0]));
    area_neg = area_w[MW-1];
    e_init[0] = edge_at(dx_q[0], dy_q[0], vx_q[0], vy_q[0], minx_q, miny_q);
    e_init[1] = edge_at(dx_q[1], dy_q[1], vx_q[1], vy_q[1], minx_q, miny_q);
    e_init[2] = edge_at(dx_q[2], dy_q[2], vx_q[2], vy_q[2], minx_q, miny_q);
  end

  logic covered, can_load, advance, last_col, last_row;

  always_comb begin
    covered  = !e_q[0][EW-1] && !e_q[1][EW-1] && !e_q[2][EW-1];
    can_load = !pix_valid_q || bus.pix_ready;
    advance  = !covered || can_load;
    last_col = (x_q == maxx_q);
    last_row = (y_q == maxy_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tri_ready_q <= 1'b0;
      pix_valid_q <= 1'b0;
      tri_done_q  <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_color_q <= '0;
      color_q     <= '0;
      minx_q      <= '0;
      maxx_q      <= '0;
      miny_q      <= '0;
      maxy_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      for (int i = 0; i < 3; i++) begin
        vx_q[i]    <= '0;
        vy_q[i]    <= '0;
        dx_q[i]    <= '0;
        dy_q[i]    <= '0;
        e_q[i]     <= '0;
        row_q[i]   <= '0;
        stepx_q[i] <= '0;
        stepy_q[i] <= '0;
      end
    end else begin
      tri_done_q <= 1'b0;
      if (pix_valid_q && bus.pix_ready) pix_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tri_ready_q <= 1'b1;
          if (bus.tri_valid && tri_ready_q) begin
            tri_ready_q <= 1'b0;
            vx_q[0]     <= crd_t'(bus.tri_v0[2*COORD_W-1:COORD_W]);
            vy_q[0]     <= crd_t'(bus.tri_v0[COORD_W-1:0]);
            vx_q[1]     <= crd_t'(bus.tri_v1[2*COORD_W-1:COORD_W]);
            vy_q[1]     <= crd_t'(bus.tri_v1[COORD_W-1:0]);
            vx_q[2]     <= crd_t'(bus.tri_v2[2*COORD_W-1:COORD_W]);
            vy_q[2]     <= crd_t'(bus.tri_v2[COORD_W-1:0]);
            color_q     <= bus.tri_color;
            state_q     <= SETUP1;
          end
        end
        SETUP1: begin
          dx_q[0] <= dlt_t'(vx_q[1]) - dlt_t'(vx_q[0]);
          dy_q[0] <= dlt_t'(vy_q[1]) - dlt_t'(vy_q[0]);
          dx_q[1] <= dlt_t'(vx_q[2]) - dlt_t'(vx_q[1]);
          dy_q[1] <= dlt_t'(vy_q[2]) - dlt_t'(vy_q[1]);
          dx_q[2] <= dlt_t'(vx_q[0]) - dlt_t'(vx_q[2]);
          dy_q[2] <= dlt_t'(vy_q[0]) - dlt_t'(vy_q[2]);
          minx_q  <= COORD_W'(clx);
          maxx_q  <= COORD_W'(chx);
          miny_q  <= COORD_W'(cly);
          maxy_q  <= COORD_W'(chy);
          state_q <= bbox_empty ? DRAIN : SETUP2;
        end
        SETUP2: begin
          x_q <= minx_q;
          y_q <= miny_q;
          // Clockwise triangles are flipped so "inside" is always E >= 0.
          for (int i = 0; i < 3; i++) begin
            if (area_neg) begin
              e_q[i]     <= -e_init[i];
              row_q[i]   <= -e_init[i];
              stepx_q[i] <= -edg_t'(dy_q[i]);
              stepy_q[i] <= -edg_t'(dx_q[i]);
            end else begin
              e_q[i]     <= e_init[i];
              row_q[i]   <= e_init[i];
              stepx_q[i] <= edg_t'(dy_q[i]);
              stepy_q[i] <= edg_t'(dx_q[i]);
            end
          end
          if ((area_w == '0) || (CULL_BACKFACE && area_neg)) state_q <= DRAIN;
          else                                               state_q <= SCAN;
        end
        SCAN: begin
          if (covered && can_load) begin
            pix_valid_q <= 1'b1;
            pix_x_q     <= x_q;
            pix_y_q     <= y_q;
            pix_color_q <= color_q;
          end
          if (advance) begin
            if (last_col) begin
              if (last_row) begin
                state_q <= DRAIN;
              end else begin
                x_q <= minx_q;
                y_q <= y_q + 1'b1;
                for (int i = 0; i < 3; i++) begin
                  e_q[i]   <= row_q[i] + stepy_q[i];
                  row_q[i] <= row_q[i] + stepy_q[i];
                end
              end
            end else begin
              x_q <= x_q + 1'b1;
              for (int i = 0; i < 3; i++) e_q[i] <= e_q[i] - stepx_q[i];
            end
          end
        end
        DRAIN: begin
          if (!pix_valid_q) begin
            tri_done_q  <= 1'b1;
            tri_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tri_ready = tri_ready_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_x     = pix_x_q;
  assign bus.pix_y     = pix_y_q;
  assign bus.pix_color = pix_color_q;
  assign bus.tri_done  = tri_done_q;
endmodule

// File: tb/tb_gl_raster_scan.sv
// tb/tb_gl_raster_scan.sv - directed bench for gl_raster_scan
module tb_gl_raster_scan;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gl_raster_scan_if #(.COORD_W(12), .NUM_CH(3), .CH_W(8)) bus ();

  gl_raster_scan #(
    .COORD_W(12), .SCREEN_W(640), .SCREEN_H(480), .NUM_CH(3), .CH_W(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Pixels with x+y<=3 inside [0,3]x[0,3], row-major.
  int ax [10] = '{0, 1, 2, 3, 0, 1, 2, 0, 1, 0};
  int ay [10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};

  logic [47:0] got[$];
  bit          done_seen;
  int          done_c;
  int          first_c;
  int          stall_err;
  logic        valid_at_done;
  logic        done_after;
  bit          accepted;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_tri(input int x0, input int y0, input int x1, input int y1,
                          input int x2, input int y2, input logic [23:0] col);
    int n;
    n = 0;
    @(negedge clk);
    bus.tri_v0    = {12'(x0), 12'(y0)};
    bus.tri_v1    = {12'(x1), 12'(y1)};
    bus.tri_v2    = {12'(x2), 12'(y2)};
    bus.tri_color = col;
    bus.tri_valid = 1'b1;
    while (!bus.tri_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    accepted = bus.tri_ready;
    @(posedge clk);
    #1;
    bus.tri_valid = 1'b0;
  endtask

  task automatic collect(input bit toggle);
    logic        prev_stall;
    logic [47:0] prev_pix;
    got.delete();
    done_seen = 1'b0;
    done_c = -1;
    first_c = -1;
    stall_err = 0;
    valid_at_done = 1'b0;
    prev_stall = 1'b0;
    prev_pix = '0;
    bus.pix_ready = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (prev_stall && !(bus.pix_valid && ({bus.pix_x, bus.pix_y, bus.pix_color} == prev_pix)))
        stall_err++;
      if (bus.pix_valid && first_c < 0) first_c = c;
      if (bus.tri_done) begin
        done_seen = 1'b1;
        done_c = c;
        valid_at_done = bus.pix_valid;
        break;
      end
      bus.pix_ready = toggle ? ~bus.pix_ready : 1'b1;
      if (bus.pix_valid && bus.pix_ready) got.push_back({bus.pix_x, bus.pix_y, bus.pix_color});
      prev_stall = bus.pix_valid && !bus.pix_ready;
      prev_pix = {bus.pix_x, bus.pix_y, bus.pix_color};
    end
    bus.pix_ready = 1'b1;
    @(negedge clk);
    done_after = bus.tri_done;
  endtask

  task automatic check_tri_a(input string tag, input logic [23:0] col);
    chk({tag, "_accept"}, 64'(accepted), 64'd1);
    chk({tag, "_done"}, 64'(done_seen), 64'd1);
    chk({tag, "_count"}, 64'(got.size()), 64'd10);
    for (int i = 0; i < 10 && i < got.size(); i++)
      chk({tag, "_pix"}, 64'(got[i]), 64'({12'(ax[i]), 12'(ay[i]), col}));
  endtask

  initial begin
    bus.tri_valid = 1'b0;
    bus.tri_v0 = '0;
    bus.tri_v1 = '0;
    bus.tri_v2 = '0;
    bus.tri_color = '0;
    bus.pix_ready = 1'b1;

    #12;
    chk("rst_tri_ready", 64'(bus.tri_ready), 64'd0);
    chk("rst_pix_valid", 64'(bus.pix_valid), 64'd0);
    chk("rst_pix_x", 64'(bus.pix_x), 64'd0);
    chk("rst_pix_y", 64'(bus.pix_y), 64'd0);
    chk("rst_pix_color", 64'(bus.pix_color), 64'd0);
    chk("rst_tri_done", 64'(bus.tri_done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_tri_ready", 64'(bus.tri_ready), 64'd1);

    // Basic 10-pixel triangle with full-rate output.
    send_tri(0, 0, 3, 0, 0, 3, 24'hA1B2C3);
    collect(1'b0);
    check_tri_a("a", 24'hA1B2C3);
    chk("a_first_valid_cycle", 64'(first_c), 64'd3);
    chk("a_done_cycle", 64'(done_c), 64'd19);
    chk("a_valid_at_done", 64'(valid_at_done), 64'd0);
    chk("a_done_pulse", 64'(done_after), 64'd0);

    // Opposite winding.
    send_tri(0, 0, 0, 3, 3, 0, 24'h123456);
    collect(1'b0);
`ifdef GL_RAST_BACKFACE_CULL_EN
    chk("cw_done", 64'(done_seen), 64'd1);
    chk("cw_count", 64'(got.size()), 64'd0);
`else
    check_tri_a("cw", 24'h123456);
`endif

    // Partly off-screen at the top-left corner.
    send_tri(-2, -2, 5, -2, -2, 5, 24'h00FF00);
    collect(1'b0);
    check_tri_a("clip", 24'h00FF00);

    // Collinear vertices: zero area.
    send_tri(0, 0, 2, 2, 4, 4, 24'hFFFFFF);
    collect(1'b0);
    chk("line_done", 64'(done_seen), 64'd1);
    chk("line_count", 64'(got.size()), 64'd0);
    chk("line_no_valid", 64'(first_c), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("line_done_cycle", 64'(done_c), 64'd3);

    // Entirely left of the screen: empty bbox.
    send_tri(-10, 0, -5, 0, -10, 5, 24'h0F0F0F);
    collect(1'b0);
    chk("off_done", 64'(done_seen), 64'd1);
    chk("off_count", 64'(got.size()), 64'd0);
    chk("off_done_cycle", 64'(done_c), 64'd2);

    // Clipped at the bottom-right screen corner.
    send_tri(638, 478, 645, 478, 638, 485, 24'h808080);
    collect(1'b0);
    chk("br_done", 64'(done_seen), 64'd1);
    chk("br_count", 64'(got.size()), 64'd4);
    if (got.size() == 4) begin
      chk("br_pix0", 64'(got[0]), 64'({12'd638, 12'd478, 24'h808080}));
      chk("br_pix1", 64'(got[1]), 64'({12'd639, 12'd478, 24'h808080}));
      chk("br_pix2", 64'(got[2]), 64'({12'd638, 12'd479, 24'h808080}));
      chk("br_pix3", 64'(got[3]), 64'({12'd639, 12'd479, 24'h808080}));
    end

    // Backpressure toggling every cycle.
    send_tri(0, 0, 3, 0, 0, 3, 24'h5A5A5A);
    collect(1'b1);
    check_tri_a("bp", 24'h5A5A5A);
    chk("bp_stable", 64'(stall_err), 64'd0);

    // Reset in the middle of a scan, then a clean triangle.
    send_tri(0, 0, 3, 0, 0, 3, 24'hC0FFEE);
    repeat (7) @(negedge clk);
    chk("mid_valid", 64'(bus.pix_valid), 64'd1);
    chk("mid_x", 64'(bus.pix_x), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_pix_valid", 64'(bus.pix_valid), 64'd0);
    chk("mrst_pix_x", 64'(bus.pix_x), 64'd0);
    chk("mrst_pix_color", 64'(bus.pix_color), 64'd0);
    chk("mrst_tri_ready", 64'(bus.tri_ready), 64'd0);
    chk("mrst_tri_done", 64'(bus.tri_done), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_tri(0, 0, 3, 0, 0, 3, 24'h314159);
    collect(1'b0);
    check_tri_a("post", 24'h314159);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
